// File: rtl/cps2_video_source.sv
// CPS2-format self-test video source: 512x262 raster, 384x224 active, 5:5:5 RGB
// with active-low syncs. Every output is registered one cycle behind the counters.
module cps2_video_source #(
  parameter int H_TOTAL      = 512,
  parameter int H_ACTIVE     = 384,
  parameter int H_SYNC_START = 400,
  parameter int H_SYNC_LEN   = 36,
  parameter int V_TOTAL      = 262,
  parameter int V_ACTIVE     = 224,
  parameter int V_SYNC_START = 236,
  parameter int V_SYNC_LEN   = 3
) (
  input  logic        PCLK_in,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [14:0] solid_color,
  output logic [4:0]  R_out,
  output logic [4:0]  G_out,
  output logic [4:0]  B_out,
  output logic        HSYNC_out,
  output logic        VSYNC_out,
  output logic        DE_out,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam logic [8:0] H_LAST     = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT      = 9'(H_ACTIVE);
  localparam logic [8:0] V_ACT      = 9'(V_ACTIVE);
  localparam logic [8:0] H_ACT_LAST = 9'(H_ACTIVE - 1);
  localparam logic [8:0] V_ACT_LAST = 9'(V_ACTIVE - 1);
  localparam logic [8:0] H_SYNC_BEG = 9'(H_SYNC_START);
  localparam logic [8:0] H_SYNC_END = 9'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [8:0] V_SYNC_BEG = 9'(V_SYNC_START);
  localparam logic [8:0] V_SYNC_END = 9'(V_SYNC_START + V_SYNC_LEN);
  localparam logic [8:0] BAR_W      = 9'(H_ACTIVE / 8);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_start;
  logic        w_run;
  logic [8:0]  r_hcnt;
  logic [8:0]  r_vcnt;
  logic [1:0]  r_pat_sel;
  logic [14:0] r_solid;
  logic        w_line_end;
  logic        w_frame_end;
  logic        w_de;
  logic        w_hsync_n;
  logic        w_vsync_n;
  logic        w_grid;
  logic [2:0]  w_bar;
  logic [14:0] w_rgb;

  // NOTE: clocked state is only ever written with <=, so every register samples pre-edge values.
  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: the default-first assignment keeps every path assigned, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (enable)  w_state_nxt = ST_RUN;
      ST_RUN:  if (!enable) w_state_nxt = ST_IDLE;
    endcase
  end

  // The idle cycle that sees enable rise is the pattern-capture cycle; counting starts after it.
  always_comb begin
    w_start = (r_state == ST_IDLE) && enable;
    w_run   = (r_state == ST_RUN) && enable;
  end

  assign w_line_end  = (r_hcnt == H_LAST);
  assign w_frame_end = w_line_end && (r_vcnt == V_LAST);

  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (!w_run) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_line_end) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 9'd1;
    end else begin
      r_hcnt <= r_hcnt + 9'd1;
    end
  end

  // Pattern changes only take effect at a frame boundary to avoid tearing.
  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n) begin
      r_pat_sel <= '0;
      r_solid   <= '0;
    end else if (w_start || (w_run && w_frame_end)) begin
      r_pat_sel <= pattern_sel;
      r_solid   <= solid_color;
    end
  end

  assign w_de      = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_hsync_n = !((r_hcnt >= H_SYNC_BEG) && (r_hcnt < H_SYNC_END));
  assign w_vsync_n = !((r_vcnt >= V_SYNC_BEG) && (r_vcnt < V_SYNC_END));
  assign w_bar     = 3'(r_hcnt / BAR_W);
  assign w_grid    = (r_hcnt[3:0] == 4'd0) || (r_vcnt[3:0] == 4'd0) ||
                     (r_hcnt == H_ACT_LAST) || (r_vcnt == V_ACT_LAST);

  // Bar order white..black maps to R = !b[1], G = !b[2], B = !b[0].
  always_comb begin
    w_rgb = '0;
    case (r_pat_sel)
      2'd0: w_rgb = {{5{~w_bar[1]}}, {5{~w_bar[2]}}, {5{~w_bar[0]}}};
      2'd1: w_rgb = {15{w_grid}};
      2'd2: w_rgb = {3{r_hcnt[8:4]}};
      2'd3: w_rgb = r_solid;
    endcase
  end

  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n) begin
      {R_out, G_out, B_out} <= '0;
      HSYNC_out             <= 1'b1;
      VSYNC_out             <= 1'b1;
      DE_out                <= 1'b0;
      frame_start           <= 1'b0;
      frame_cnt             <= '0;
    end else if (w_run) begin
      {R_out, G_out, B_out} <= w_de ? w_rgb : 15'd0;
      HSYNC_out             <= w_hsync_n;
      VSYNC_out             <= w_vsync_n;
      DE_out                <= w_de;
      frame_start           <= (r_hcnt == 9'd0) && (r_vcnt == 9'd0);
      if (w_frame_end) frame_cnt <= frame_cnt + 8'd1;
    end else begin
      {R_out, G_out, B_out} <= '0;
      HSYNC_out             <= 1'b1;
      VSYNC_out             <= 1'b1;
      DE_out                <= 1'b0;
      frame_start           <= 1'b0;
    end
  end

endmodule
